// File: rtl/core_ctrl.sv
// core_ctrl: pipeline sequencer for the xRV32I core.
// Each cycle it decides whether PC, IF/ID and ID/EX advance, hold or flush.
// The inputs are EX redirects, ID load-use hazards, bus wait states and
// debug halt/resume.
// It also keeps a saturating count of cycles in which the PC was held.
//
// Control contract: every request input is a level that is sampled each
// cycle. There is no valid/ready handshake. The outputs are combinational
// from the current state and the inputs, and they act at the next rising
// edge. While rst is low, every output reads 0.
module core_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_CYCLES = 1,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_req_in,
  input  logic [ADDR_WIDTH-1:0] jump_addr_in,
  input  logic                  load_use_in,
  input  logic                  bus_busy_in,
  input  logic                  halt_req_in,
  input  logic                  resume_req_in,
  output logic                  jump_flag_out,
  output logic [ADDR_WIDTH-1:0] jump_addr_out,
  output logic                  hold_pc_out,
  output logic                  hold_if_id_out,
  output logic                  hold_id_ex_out,
  output logic                  flush_if_id_out,
  output logic                  flush_id_ex_out,
  output logic                  halted_out,
  output logic [1:0]            state_out,
  output logic [31:0]           stall_cnt_out
);

  localparam int CNT_MAX = (FLUSH_CYCLES > STALL_CYCLES) ? FLUSH_CYCLES : STALL_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Set for the single RUN cycle right after a resume, so that a halt
  // request still held high does not immediately re-enter HALT.
  logic             resumed_q, resumed_d;
  logic [31:0]      stall_cnt_q;

  // State, remaining-cycle counter and the post-resume marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      resumed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      resumed_q <= resumed_d;
    end
  end

  // Next state and all control outputs, by priority: HALT, bus wait, jump, load-use, halt.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    resumed_d       = 1'b0;
    jump_flag_out   = 1'b0;
    jump_addr_out   = '0;
    hold_pc_out     = 1'b0;
    hold_if_id_out  = 1'b0;
    hold_id_ex_out  = 1'b0;
    flush_if_id_out = 1'b0;
    flush_id_ex_out = 1'b0;
    halted_out      = 1'b0;
    if (rst) begin
      if (state_q == ST_HALT) begin
        halted_out     = 1'b1;
        hold_pc_out    = 1'b1;
        hold_if_id_out = 1'b1;
        hold_id_ex_out = 1'b1;
        if (resume_req_in) begin
          state_d   = ST_RUN;
          resumed_d = 1'b1;
        end
      end else if (bus_busy_in) begin
        // Whole pipeline frozen; state and counter keep their values.
        hold_pc_out    = 1'b1;
        hold_if_id_out = 1'b1;
        hold_id_ex_out = 1'b1;
      end else if (state_q == ST_FLUSH) begin
        flush_if_id_out = 1'b1;
        flush_id_ex_out = 1'b1;
        if (cnt_q == CNT_ONE) state_d = ST_RUN;
        cnt_d = cnt_q - CNT_ONE;
      end else if (jump_req_in) begin
        // Taken in RUN or STALL; a jump in STALL aborts the stall.
        jump_flag_out   = 1'b1;
        jump_addr_out   = jump_addr_in;
        flush_if_id_out = 1'b1;
        flush_id_ex_out = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end else if (state_q == ST_STALL) begin
        hold_pc_out     = 1'b1;
        hold_if_id_out  = 1'b1;
        flush_id_ex_out = 1'b1;
        if (cnt_q == CNT_ONE) state_d = ST_RUN;
        cnt_d = cnt_q - CNT_ONE;
      end else if (load_use_in) begin
        // Hold the front of the pipe and insert a bubble into ID/EX.
        hold_pc_out     = 1'b1;
        hold_if_id_out  = 1'b1;
        flush_id_ex_out = 1'b1;
        if (STALL_CYCLES > 1) begin
          state_d = ST_STALL;
          cnt_d   = STALL_LOAD;
        end
      end else if (halt_req_in && !resumed_q) begin
        state_d = ST_HALT;
      end
    end
  end

  // Saturating count of edges that see hold_pc_out asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (hold_pc_out && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign state_out     = rst ? state_q : 2'd0;
  assign stall_cnt_out = rst ? stall_cnt_q : 32'd0;

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Pipeline sequencer for the xRV32I core.
- Sits beside core_if_id / core_id / core_ex.
- Decides each cycle whether the PC, IF/ID and ID/EX stages advance, hold, or are flushed.
- Sources: EX jump/branch redirects, ID load-use hazards, bus wait states and debug halt/resume.
- Also keeps a saturating stall-cycle counter for performance inspection.

Parameters:
- FLUSH_CYCLES, 2: total cycles IF/ID and ID/EX are flushed per taken jump (>=1).
- STALL_CYCLES, 1: total cycles PC and IF/ID are held per load-use hazard (>=1).
- ADDR_WIDTH, 32: jump address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- jump_req_in  in  1  EX: branch/jump taken this cycle.
- jump_addr_in  in  ADDR_WIDTH  EX: redirect target.
- load_use_in  in  1  ID: source register depends on a load currently in EX.
- bus_busy_in  in  1  memory access outstanding; freeze whole pipeline.
- halt_req_in  in  1  debug halt request (level).
- resume_req_in  in  1  debug resume request (level).
- jump_flag_out  out  1  redirect PC to jump_addr_out at next edge.
- jump_addr_out  out  ADDR_WIDTH  redirect target.
- hold_pc_out  out  1  PC keeps value.
- hold_if_id_out  out  1  IF/ID register keeps value.
- hold_id_ex_out  out  1  ID/EX register keeps value.
- flush_if_id_out  out  1  IF/ID loads NOP.
- flush_id_ex_out  out  1  ID/EX loads NOP.
- halted_out  out  1  core is in HALT.
- state_out  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH, 3 HALT.
- stall_cnt_out  out  32  saturating count of cycles with hold_pc_out=1.

Behaviour:
- Reset (rst=0, async):
  - state=RUN, internal counter=0, stall_cnt_out=0.
  - While rst=0, every output is forced to 0.
- Outputs are combinational from the current state plus inputs. State and counters update on the rising clk edge.
- Event priority each cycle:
  1. bus_busy_in
  2. jump_req_in
  3. load_use_in
  4. halt_req_in
- bus_busy_in=1 (any state except HALT):
  - hold_pc/hold_if_id/hold_id_ex=1, all flushes=0, jump_flag_out=0.
  - State and counter are frozen. Pending jump, load-use or halt is evaluated once busy drops.
- RUN:
  - Jump: jump_flag_out=1, jump_addr_out=jump_addr_in, both flushes=1 this cycle. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; else stay in RUN.
  - Load-use: hold_pc=1, hold_if_id=1, flush_id_ex=1 (bubble). If STALL_CYCLES>1, go to STALL with cnt=STALL_CYCLES-1; else stay in RUN.
  - Halt: halt_req_in with no other event: no holds this cycle; go to HALT at the next edge.
  - No event: all control outputs 0.
- STALL:
  - Same outputs as the RUN load-use case. cnt decrements; go to RUN when cnt==1 at the edge.
  - A jump_req_in in STALL aborts the stall and is handled exactly as a jump in RUN.
- FLUSH:
  - Both flushes=1. cnt decrements; go to RUN when cnt==1.
  - jump_req_in and load_use_in are ignored; halt_req_in waits until RUN.
- HALT:
  - halted_out=1, all holds=1, flushes=0.
  - bus_busy_in, jump_req_in and load_use_in are ignored.
  - resume_req_in=1 returns to RUN at the next edge; halt_req_in is not re-sampled in that first RUN cycle.
  - If halt_req_in and resume_req_in are both 1, resume wins.
- jump_addr_out = jump_addr_in whenever jump_flag_out=1, otherwise 0.
- stall_cnt_out:
  - Increments by 1 on every edge where hold_pc_out=1, including bus wait and HALT.
  - Saturates at 0xFFFF_FFFF, no wrap.
- Reset asserted mid-FLUSH, STALL or HALT returns immediately to RUN with zeroed outputs. No pending event survives reset.

Test Plan:
- Reset → release, no inputs: state_out=0 and all outputs 0 for 10 cycles; stall_cnt_out=0.
- jump_req_in=1 for 1 cycle, jump_addr_in=0x0000_0100, FLUSH_CYCLES=2:
  - Cycle 0: jump_flag_out=1, addr=0x100, both flushes=1.
  - Cycle 1: state=FLUSH, flushes=1, jump_flag_out=0.
  - Cycle 2: RUN, all 0.
- load_use_in=1 for 1 cycle, STALL_CYCLES=1: hold_pc=hold_if_id=flush_id_ex=1 for exactly one cycle; stall_cnt_out becomes 1.
- bus_busy_in=1 for 3 cycles while jump_req_in=1 with addr 0x200: holds=1 and jump_flag_out=0 for 3 cycles; then a 1-cycle jump with addr 0x200 and FLUSH; stall_cnt_out=3.
- Halt/resume:
  - halt_req_in=1 in RUN: HALT next cycle, halted_out=1, holds=1.
  - jump_req_in during HALT: no redirect.
  - resume_req_in=1: RUN next cycle.
  - halt during FLUSH: deferred until RUN.
- Reset pulse mid-FLUSH with STALL_CYCLES=3 load-use also asserted: outputs go to 0 asynchronously; after release state=RUN and stall_cnt_out=0.
- Saturation: preload via 2^32 hold cycles (bench force of the counter to 0xFFFF_FFFE, then 3 hold cycles): stall_cnt_out ends at 0xFFFF_FFFF.
